// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO result registers.
// Optional macro MULTDIV_DIVZERO_DETECT_EN: short-circuit DIV by zero at acceptance and flag div_zero.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] HI_out,
   output logic [WIDTH-1:0] LO_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

   state_t         state, next_state, accept_state;
   logic           accept, div_zero_req;
   logic [CW-1:0]  count;

   logic [WIDTH:0]   acc, m, booth_sum, acc_n;
   logic [WIDTH-1:0] q, q_n;
   logic             q_m1, q_m1_n;

   logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n, abs_a, abs_b;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH+1:0] trial;
   logic             sign_a, sign_b;

`ifdef MULTDIV_DIVZERO_DETECT_EN
   assign div_zero_req = op && (op_b == '0);
`else
   assign div_zero_req = 1'b0;
`endif

   assign accept       = start && (state == IDLE || state == DONE);
   assign accept_state = !op ? MULT : (div_zero_req ? DONE : DIV);
   assign abs_a        = op_a[WIDTH-1] ? -op_a : op_a;
   assign abs_b        = op_b[WIDTH-1] ? -op_b : op_b;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) next_state = accept_state;
         MULT: begin
            busy = 1'b1;
            if (count == LAST) next_state = DONE;
         end
         DIV: begin
            busy = 1'b1;
            if (count == LAST) next_state = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = start ? accept_state : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Booth step: the WIDTH+1-bit accumulator keeps acc - M from overflowing when M is the most negative value.
   always_comb begin
      case ({q[0], q_m1})
         2'b01:   booth_sum = acc + m;
         2'b10:   booth_sum = acc - m;
         default: booth_sum = acc;
      endcase
      {acc_n, q_n, q_m1_n} = {booth_sum[WIDTH], booth_sum, q};
   end

   // Restoring step on magnitudes; a borrow out of the trial subtraction means restore.
   always_comb begin
      rem_shift = {rem, quo[WIDTH-1]};
      trial     = {1'b0, rem_shift} - {2'b00, dvs};
      if (trial[WIDTH+1]) begin
         rem_n = rem_shift[WIDTH-1:0];
         quo_n = {quo[WIDTH-2:0], 1'b0};
      end else begin
         rem_n = trial[WIDTH-1:0];
         quo_n = {quo[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count    <= '0;
         acc      <= '0;
         m        <= '0;
         q        <= '0;
         q_m1     <= 1'b0;
         rem      <= '0;
         quo      <= '0;
         dvs      <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         HI_out   <= '0;
         LO_out   <= '0;
      end else if (accept) begin
         count    <= '0;
         acc      <= '0;
         m        <= {op_a[WIDTH-1], op_a};
         q        <= op_b;
         q_m1     <= 1'b0;
         rem      <= '0;
         quo      <= abs_a;
         dvs      <= abs_b;
         sign_a   <= op_a[WIDTH-1];
         sign_b   <= op_b[WIDTH-1];
         div_zero <= div_zero_req;
      end else begin
         case (state)
            MULT: begin
               if (count == LAST) begin
                  HI_out <= acc[WIDTH-1:0];
                  LO_out <= q;
               end else begin
                  acc   <= acc_n;
                  q     <= q_n;
                  q_m1  <= q_m1_n;
                  count <= count + CW'(1);
               end
            end
            DIV: begin
               if (count == LAST) begin
                  quo <= (sign_a ^ sign_b) ? -quo : quo;
                  rem <= sign_a ? -rem : rem;
               end else begin
                  rem   <= rem_n;
                  quo   <= quo_n;
                  count <= count + CW'(1);
               end
            end
            FIX: begin
               HI_out   <= rem;
               LO_out   <= quo;
               div_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit: results, latency, done pulse, back-to-back, ignored start, reset abort.
module tb_mult_div_unit;

   logic        clock = 1'b0;
   logic        reset, start, op;
   logic [31:0] op_a, op_b;
   logic        busy, done, div_zero;
   logic [31:0] HI_out, LO_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   logic [31:0] r_hi, r_lo;
   logic        r_dz, r_busy0, r_busyd;
   int          r_lat;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .div_zero(div_zero), .HI_out(HI_out), .LO_out(LO_out)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Called at a negedge; returns at the negedge of the done cycle (lat = edges after E0 before done).
   task automatic applyStimulus(input logic op_sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                                output int lat, output logic busy0, output logic busyd);
      op    = op_sel;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      lat = 0;
      @(negedge clock);
      busy0 = busy;
      while (!done && lat < 200) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      hi    = HI_out;
      lo    = LO_out;
      dz    = div_zero;
      busyd = busy;
   endtask

   task automatic checkResult(input string name, input logic [31:0] hi, input logic [31:0] lo,
                              input logic dz, input int lat);
      checkOutput({name, " HI"}, r_hi, hi);
      checkOutput({name, " LO"}, r_lo, lo);
      checkOutput({name, " div_zero"}, 32'(r_dz), 32'(dz));
      checkOutput({name, " latency"}, 32'(r_lat), 32'(lat));
      checkOutput({name, " busy after E0"}, 32'(r_busy0), (lat > 0) ? 32'd1 : 32'd0);
      checkOutput({name, " busy in done cycle"}, 32'(r_busyd), 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
      vecs[1] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 33};
      vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33};
      vecs[3] = '{1'b0, 32'd0,        32'h80000000, 32'h00000000, 32'h00000000, 33};
      vecs[4] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       34};
      vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
      vecs[6] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34};
      vecs[7] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       34};
      vecs[8] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       34};

      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset div_zero", 32'(div_zero), 32'd0);
      checkOutput("reset HI", HI_out, 32'd0);
      checkOutput("reset LO", LO_out, 32'd0);

      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_dz, r_lat, r_busy0, r_busyd);
         checkResult($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].lat);
         @(negedge clock);
         checkOutput($sformatf("vec%0d done one cycle", i), 32'(done), 32'd0);
         checkOutput($sformatf("vec%0d HI held", i), HI_out, vecs[i].hi);
      end

      // Divide by zero follows vec8, so HI/LO hold 2/14 beforehand.
      applyStimulus(1'b1, 32'd5, 32'd0, r_hi, r_lo, r_dz, r_lat, r_busy0, r_busyd);
`ifdef MULTDIV_DIVZERO_DETECT_EN
      checkResult("div 5/0", 32'd2, 32'd14, 1'b1, 0);
      @(negedge clock);
      checkOutput("div_zero holds", 32'(div_zero), 32'd1);
      applyStimulus(1'b0, 32'd2, 32'd2, r_hi, r_lo, r_dz, r_lat, r_busy0, r_busyd);
      checkResult("mult after div0", 32'd0, 32'd4, 1'b0, 33);
`else
      checkResult("div 5/0", 32'd5, 32'hFFFFFFFF, 1'b0, 34);
      @(negedge clock);
      applyStimulus(1'b1, 32'hFFFFFFFB, 32'd0, r_hi, r_lo, r_dz, r_lat, r_busy0, r_busyd);
      checkResult("div -5/0", 32'hFFFFFFFB, 32'd1, 1'b0, 34);
`endif

      // Back-to-back: DIV issued during the MULT done cycle.
      @(negedge clock);
      applyStimulus(1'b0, 32'h80000000, 32'h80000000, r_hi, r_lo, r_dz, r_lat, r_busy0, r_busyd);
      checkResult("mult min*min", 32'h40000000, 32'h00000000, 1'b0, 33);
      applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, r_hi, r_lo, r_dz, r_lat, r_busy0, r_busyd);
      checkResult("b2b div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);

      // A second start at E5 must be ignored.
      @(negedge clock);
      @(negedge clock);
      op = 1'b0; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(posedge clock);
      #1 begin op = 1'b1; op_a = 32'd100; op_b = 32'd100; start = 1'b1; end
      @(posedge clock);
      #1 start = 1'b0;
      r_lat = 5;
      @(negedge clock);
      while (!done && r_lat < 200) begin
         @(posedge clock);
         r_lat++;
         @(negedge clock);
      end
      checkOutput("ignored start latency", 32'(r_lat), 32'd33);
      checkOutput("ignored start HI", HI_out, 32'd0);
      checkOutput("ignored start LO", LO_out, 32'd12);

      // Reset shortly after E10 aborts and clears everything at once.
      @(negedge clock);
      @(negedge clock);
      op = 1'b0; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (10) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort HI", HI_out, 32'd0);
      checkOutput("abort LO", LO_out, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(1'b0, 32'd2, 32'd3, r_hi, r_lo, r_dz, r_lat, r_busy0, r_busyd);
      checkResult("mult 2*3 after reset", 32'd0, 32'd6, 1'b0, 33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
